// File: rtl/univ_shift_reg_burst.sv
// N-bit universal shift register (load/shift/rotate/asr/clear) with a burst sequencer
// that repeats one latched operation for a programmed number of cycles.
//
// state   | meaning
// S_IDLE  | single-step ctrl each edge; start launches a burst
// S_BURST | applying latched op_q, remaining steps in rem_q
// S_DONE  | one-cycle completion pulse, q holds
module univ_shift_reg_burst #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ctrl,
  input  logic [N-1:0]     d,
  input  logic             si_l,
  input  logic             si_r,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [N-1:0]     q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;

  function automatic logic [N-1:0] apply_op(
    input logic [2:0]   op,
    input logic [N-1:0] cur,
    input logic [N-1:0] din,
    input logic         sl,
    input logic         sr
  );
    logic [N-1:0] r;
    case (op)
      3'b000:  r = cur;
      3'b001:  r = din;
      3'b010:  r = {cur[N-2:0], sl};
      3'b011:  r = {sr, cur[N-1:1]};
      3'b100:  r = {cur[N-2:0], cur[N-1]};
      3'b101:  r = {cur[0], cur[N-1:1]};
      3'b110:  r = {cur[N-1], cur[N-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            state_d = S_DONE;
          end else begin
            q_d  = apply_op(ctrl, q_q, d, si_l, si_r);
            op_d = ctrl;
            if (burst_len == CNT_W'(1)) begin
              state_d = S_DONE;
            end else begin
              rem_d   = burst_len - CNT_W'(1);
              state_d = S_BURST;
            end
          end
        end else begin
          q_d = apply_op(ctrl, q_q, d, si_l, si_r);
        end
      end
      S_BURST: begin
        q_d   = apply_op(op_q, q_q, d, si_l, si_r);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // reset also drops the latched op so an aborted burst leaves nothing behind
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign q    = q_q;
  assign so_l = q_q[N-1];
  assign so_r = q_q[0];
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Directed bench for univ_shift_reg_burst with hand-computed expected values.
module tb_univ_shift_reg_burst;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ctrl;
  logic [7:0] d;
  logic       si_l, si_r, start;
  logic [3:0] burst_len;
  logic [7:0] q;
  logic       so_l, so_r, busy, done;

  int checks = 0;
  int failures = 0;

  univ_shift_reg_burst #(.N(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ctrl(ctrl), .d(d), .si_l(si_l), .si_r(si_r),
    .start(start), .burst_len(burst_len), .q(q), .so_l(so_l), .so_r(so_r),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic single(input logic [2:0] c, input logic [7:0] dv);
    ctrl = c;
    d = dv;
    step();
  endtask

  initial begin
    reset = 1'b1; ctrl = 3'b000; d = 8'h00; si_l = 1'b0; si_r = 1'b0;
    start = 1'b0; burst_len = 4'd0;
    step(); step();
    reset = 1'b0;

    // 1: reset after random single-step activity
    for (int i = 0; i < 6; i++) begin
      ctrl = 3'($urandom_range(0, 6)); d = 8'($urandom); si_l = 1'($urandom); si_r = 1'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    chk_st("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    // 2: load / shl / shr with serial outputs
    si_l = 1'b1; si_r = 1'b0;
    single(3'b001, 8'h05);
    chk("load05", 32'(q), 32'h05);
    chk("load05.so", 32'({so_l, so_r}), 32'b01);
    single(3'b010, 8'h00);
    chk("shl", 32'(q), 32'h0B);
    chk("shl.so", 32'({so_l, so_r}), 32'b01);
    single(3'b011, 8'h00);
    chk("shr", 32'(q), 32'h05);
    chk("shr.so", 32'({so_l, so_r}), 32'b01);

    // 3: asr, ror, rol
    single(3'b001, 8'h90);
    single(3'b110, 8'h00); chk("asr1", 32'(q), 32'hC8);
    single(3'b110, 8'h00); chk("asr2", 32'(q), 32'hE4);
    for (int i = 0; i < 6; i++) single(3'b110, 8'h00);
    chk("asr_sat", 32'(q), 32'hFF);
    single(3'b001, 8'h01);
    single(3'b101, 8'h00); chk("ror", 32'(q), 32'h80);
    single(3'b100, 8'h00); chk("rol", 32'(q), 32'h01);
    single(3'b001, 8'h5A);
    for (int i = 0; i < 8; i++) single(3'b101, 8'h00);
    chk("ror8", 32'(q), 32'h5A);

    // 4: rol burst of 3, ctrl changed during burst is ignored
    single(3'b001, 8'h81);
    start = 1'b1; ctrl = 3'b100; burst_len = 4'd3;
    step(); chk_st("b4s1", 8'h03, 1'b1, 1'b0);
    start = 1'b0; ctrl = 3'b011;
    step(); chk_st("b4s2", 8'h06, 1'b1, 1'b0);
    step(); chk_st("b4s3", 8'h0C, 1'b1, 1'b1);
    ctrl = 3'b000;
    step(); chk_st("b4idle", 8'h0C, 1'b0, 1'b0);

    // 5: zero-length burst, then start while busy is dropped
    start = 1'b1; ctrl = 3'b111; burst_len = 4'd0;
    step(); chk_st("b0", 8'h0C, 1'b1, 1'b1);
    start = 1'b0; ctrl = 3'b000;
    step(); chk_st("b0idle", 8'h0C, 1'b0, 1'b0);
    start = 1'b1; ctrl = 3'b000; burst_len = 4'd3;
    step(); chk_st("b5s1", 8'h0C, 1'b1, 1'b0);
    start = 1'b1; ctrl = 3'b111; burst_len = 4'd1;
    step(); chk_st("b5s2", 8'h0C, 1'b1, 1'b0);
    start = 1'b0; ctrl = 3'b000;
    step(); chk_st("b5s3", 8'h0C, 1'b1, 1'b1);
    step(); chk_st("b5idle", 8'h0C, 1'b0, 1'b0);
    step(); chk_st("b5nore", 8'h0C, 1'b0, 1'b0);

    // 6: reset aborts a shl burst after 4 steps
    single(3'b001, 8'h01);
    si_l = 1'b0;
    start = 1'b1; ctrl = 3'b010; burst_len = 4'd10;
    step();
    start = 1'b0; ctrl = 3'b000;
    step(); step(); step();
    chk_st("b6s4", 8'h10, 1'b1, 1'b0);
    reset = 1'b1;
    step(); chk_st("b6rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    single(3'b001, 8'hA5); chk_st("b6single", 8'hA5, 1'b0, 1'b0);
    single(3'b000, 8'h00); chk_st("b6hold", 8'hA5, 1'b0, 1'b0);
    single(3'b000, 8'h00); chk_st("b6hold2", 8'hA5, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
